// File: rtl/audio_pkg.sv
// Shared definitions for the audio output path.
// Holds the mix/gain widths, the fade state encoding and the default source
// levels used by audio_dac.
// No ports: this is a package imported by the audio RTL.
package audio_pkg;

  // Width of the mixed / scaled PCM level
  localparam int MIX_W  = 10;
  // Gain runs 0..16, so it needs 5 bits
  localparam int GAIN_W = 5;
  localparam logic [GAIN_W-1:0] GAIN_MAX = 5'd16;

  // Default contribution of each single-bit ULA source to the mix
  localparam logic [7:0] BEEP_LEVEL_DEFAULT = 8'd96;
  localparam logic [7:0] EAR_LEVEL_DEFAULT  = 8'd32;
  localparam logic [7:0] MIC_LEVEL_DEFAULT  = 8'd16;

  // Gain changes by one step every 2^RAMP_LOG2 clocks while fading
  localparam int RAMP_LOG2_DEFAULT = 8;

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    RUN      = 2'd1,
    FADE_OUT = 2'd2,
    MUTED    = 2'd3
  } fade_state_e;

endpackage

// File: rtl/sigma_delta1.sv
// First-order sigma-delta modulator.
// Turns a W-bit unsigned level into a 1-bit stream whose long-run density of
// ones is din / 2^W. A constant din of 0 yields a constant 0 output.
// Ports:
//   clock - clock
//   reset - asynchronous active-high reset (clears accumulator and output)
//   din   - W-bit unsigned level
//   dout  - registered 1-bit stream (carry out of the accumulator)
module sigma_delta1 #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W-1:0] acc_q, acc_d;
  logic         dout_q, dout_d;
  logic [W:0]   acc_sum;

  // The carry of each accumulation is the output bit; only the low W bits
  // are kept, so the accumulator wraps naturally.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, din};
    acc_d   = acc_sum[W-1:0];
    dout_d  = acc_sum[W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/audio_dac.sv
// Audio mixer / DAC front end.
// Mixes the Soundbox sample, an auxiliary channel and the ULA beeper/ear/mic
// bits into a saturated 10-bit level, scales it by a 0..16 gain that ramps
// for click-free start-up and muting, and drives a 1-bit sigma-delta stream.
// Ports:
//   clock    - system clock
//   reset    - asynchronous active-high reset
//   ce       - sample strobe; sources are captured only when high
//   mute     - 1 fades to silence, 0 fades to full gain
//   soundbox - 8-bit unsigned Soundbox sample
//   aux      - 8-bit unsigned auxiliary channel
//   beeper   - ULA speaker bit
//   ear      - ULA ear bit
//   mic      - ULA mic bit
//   pcm      - 10-bit scaled level for digital consumers
//   dout     - sigma-delta bitstream for the RC-filtered pin
//   busy     - high while a fade is in progress
module audio_dac
  import audio_pkg::*;
#(
  parameter logic [7:0] BEEP_LEVEL = BEEP_LEVEL_DEFAULT,
  parameter logic [7:0] EAR_LEVEL  = EAR_LEVEL_DEFAULT,
  parameter logic [7:0] MIC_LEVEL  = MIC_LEVEL_DEFAULT,
  parameter int         RAMP_LOG2  = RAMP_LOG2_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             mute,
  input  logic [7:0]       soundbox,
  input  logic [7:0]       aux,
  input  logic             beeper,
  input  logic             ear,
  input  logic             mic,
  output logic [MIX_W-1:0] pcm,
  output logic             dout,
  output logic             busy
);

  localparam logic [MIX_W:0] MIX_LIMIT = 11'd1023;

  logic [MIX_W-1:0]       sum_q, sum_d;
  logic [MIX_W-1:0]       pcm_q, pcm_d;
  logic [GAIN_W-1:0]      gain_q, gain_d;
  logic [RAMP_LOG2-1:0]   ramp_q, ramp_d;
  fade_state_e            state_q, state_d;

  logic [MIX_W:0]         mix_sum;
  logic [MIX_W+GAIN_W-1:0] product;
  logic                   fading;
  logic                   step;
  logic                   unused_product_bits;

  // Mix: 11-bit sum of all sources, clamped to the 10-bit range and captured
  // only on the sample strobe so glitches between strobes never reach the mix.
  always_comb begin
    mix_sum = {3'b000, soundbox} + {3'b000, aux}
            + (beeper ? {3'b000, BEEP_LEVEL} : '0)
            + (ear    ? {3'b000, EAR_LEVEL}  : '0)
            + (mic    ? {3'b000, MIC_LEVEL}  : '0);
    sum_d = sum_q;
    if (ce) begin
      sum_d = (mix_sum > MIX_LIMIT) ? '1 : mix_sum[MIX_W-1:0];
    end
  end

  // Gain: a full-scale gain of 16 maps to unity, hence the divide by 16.
  always_comb begin
    product = {{GAIN_W{1'b0}}, sum_q} * {{MIX_W{1'b0}}, gain_q};
    pcm_d   = product[MIX_W+3:4];
  end

  assign unused_product_bits = ^{product[MIX_W+GAIN_W-1:MIX_W+4], product[3:0]};

  // Fade control. A step fires on the clock where the ramp counter wraps to
  // zero. A mute change on a step clock still applies that step in the old
  // direction while the state flips. The counter restarts whenever a fade
  // finishes so the next fade gets a full first period.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    ramp_d  = ramp_q;
    fading  = (state_q == FADE_IN) || (state_q == FADE_OUT);
    step    = fading && (ramp_q == {RAMP_LOG2{1'b1}});

    if (fading) begin
      ramp_d = ramp_q + 1'b1;
    end

    case (state_q)
      FADE_IN: begin
        if (step && (gain_q < GAIN_MAX)) begin
          gain_d = gain_q + 1'b1;
        end
        if (mute) begin
          state_d = FADE_OUT;
        end else if (gain_d == GAIN_MAX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        gain_d = GAIN_MAX;
        if (mute) begin
          state_d = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (step && (gain_q != '0)) begin
          gain_d = gain_q - 1'b1;
        end
        if (!mute) begin
          state_d = FADE_IN;
        end else if (gain_d == '0) begin
          state_d = MUTED;
        end
      end
      MUTED: begin
        gain_d = '0;
        if (!mute) begin
          state_d = FADE_IN;
        end
      end
      default: begin
        state_d = FADE_IN;
        gain_d  = '0;
      end
    endcase

    if ((state_d == RUN) || (state_d == MUTED)) begin
      ramp_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      pcm_q   <= '0;
      gain_q  <= '0;
      ramp_q  <= '0;
      state_q <= FADE_IN;
    end else begin
      sum_q   <= sum_d;
      pcm_q   <= pcm_d;
      gain_q  <= gain_d;
      ramp_q  <= ramp_d;
      state_q <= state_d;
    end
  end

  sigma_delta1 #(
    .W(MIX_W)
  ) u_sigma_delta (
    .clock (clock),
    .reset (reset),
    .din   (pcm_q),
    .dout  (dout)
  );

  assign pcm  = pcm_q;
  assign busy = (state_q == FADE_IN) || (state_q == FADE_OUT);

endmodule

// File: tb/tb_audio_dac.sv
// Self-checking bench for audio_dac.
// A default-level instance and a saturating instance (all levels 255) share
// the same stimulus. Expected pcm values are queued with the clock on which
// they are due and a monitor compares them on the falling edge.
module tb_audio_dac;

  logic       clock;
  logic       reset;
  logic       ce;
  logic       mute;
  logic [7:0] soundbox;
  logic [7:0] aux;
  logic       beeper;
  logic       ear;
  logic       mic;
  logic [9:0] pcm;
  logic       dout;
  logic       busy;
  logic [9:0] pcm_sat;
  logic       dout_sat;
  logic       busy_sat;
  logic       sd_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    string name;
    int    due;
    int    value;
    bit    sat;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [7:0] sb;
    logic [7:0] ax;
    logic       b;
    logic       e;
    logic       m;
    int         exp_pcm;
    int         exp_sat;
  } vec_t;

  vec_t vecs[8];

  int  sd_ones = 0;
  bit  sd_done = 0;

  audio_dac dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .mute     (mute),
    .soundbox (soundbox),
    .aux      (aux),
    .beeper   (beeper),
    .ear      (ear),
    .mic      (mic),
    .pcm      (pcm),
    .dout     (dout),
    .busy     (busy)
  );

  audio_dac #(
    .BEEP_LEVEL (8'd255),
    .EAR_LEVEL  (8'd255),
    .MIC_LEVEL  (8'd255)
  ) dut_sat (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .mute     (mute),
    .soundbox (soundbox),
    .aux      (aux),
    .beeper   (beeper),
    .ear      (ear),
    .mic      (mic),
    .pcm      (pcm_sat),
    .dout     (dout_sat),
    .busy     (busy_sat)
  );

  sigma_delta1 #(
    .W(10)
  ) sd_core (
    .clock (clock),
    .reset (reset),
    .din   (10'd300),
    .dout  (sd_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expect_pcm(input string name, input int delay, input int value, input bit sat);
    exp_t e;
    e.name  = name;
    e.due   = cyc + delay;
    e.value = value;
    e.sat   = sat;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: compare every entry due on this clock
  always @(negedge clock) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check_output(sb_q[i].name, sb_q[i].sat ? int'(pcm_sat) : int'(pcm), sb_q[i].value);
        sb_q.delete(i);
      end
    end
  end

  // Standalone modulator: ones in the first 1024 clocks after the first
  // reset release, starting from a zero accumulator
  initial begin
    @(negedge reset);
    repeat (1024) begin
      @(posedge clock);
      #1;
      if (sd_dout) sd_ones++;
    end
    sd_done = 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one vector with a single ce pulse, then scramble the sources while
  // ce is low; the result must still be the captured vector two clocks later
  task automatic apply_stimulus(input vec_t v, input string tag);
    soundbox = v.sb;
    aux      = v.ax;
    beeper   = v.b;
    ear      = v.e;
    mic      = v.m;
    ce       = 1'b1;
    expect_pcm({tag, "_pcm"}, 2, v.exp_pcm, 1'b0);
    expect_pcm({tag, "_sat"}, 2, v.exp_sat, 1'b1);
    tick(1);
    ce       = 1'b0;
    soundbox = 8'($urandom);
    aux      = 8'($urandom);
    beeper   = 1'($urandom);
    tick(1);
  endtask

  initial begin
    int ones;
    int guard;
    vec_t v;

    vecs[0] = '{8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 0,   0};
    vecs[1] = '{8'd200, 8'd0,   1'b0, 1'b0, 1'b0, 200, 200};
    vecs[2] = '{8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 654, 1023};
    vecs[3] = '{8'd10,  8'd20,  1'b1, 1'b0, 1'b0, 126, 285};
    vecs[4] = '{8'd0,   8'd0,   1'b0, 1'b1, 1'b1, 48,  510};
    vecs[5] = '{8'd128, 8'd100, 1'b0, 1'b1, 1'b0, 260, 483};
    vecs[6] = '{8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 510, 510};
    vecs[7] = '{8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 96,  255};

    reset    = 1'b1;
    ce       = 1'b1;
    mute     = 1'b0;
    soundbox = 8'd200;
    aux      = 8'd0;
    beeper   = 1'b0;
    ear      = 1'b0;
    mic      = 1'b0;

    // Reset state
    tick(3);
    check_output("reset_pcm", int'(pcm), 0);
    check_output("reset_dout", int'(dout), 0);

    // Fade-in from reset release: one gain step every 256 clocks
    reset = 1'b0;
    check_output("busy_after_release", int'(busy), 1);
    for (int k = 0; k <= 16; k++) begin
      expect_pcm($sformatf("fade_in_k%0d", k), 256 * k + 1, (200 * k) >> 4, 1'b0);
    end
    tick(4095);
    check_output("fade_in_busy_before_end", int'(busy), 1);
    tick(1);
    check_output("fade_in_done", int'(busy), 0);
    tick(2);
    check_output("sd_core_density", sd_done ? sd_ones : -1, 300);

    // Mix table at full gain
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Sources ignored while ce is low
    v = '{8'd10, 8'd0, 1'b0, 1'b0, 1'b0, 10, 10};
    apply_stimulus(v, "hold_setup");
    soundbox = 8'd250;
    beeper   = 1'b0;
    aux      = 8'd0;
    expect_pcm("hold_while_ce_low", 3, 10, 1'b0);
    tick(3);
    ce = 1'b1;
    expect_pcm("hold_one_after_ce", 1, 10, 1'b0);
    expect_pcm("ce_pulse_250", 2, 250, 1'b0);
    tick(1);
    ce = 1'b0;
    tick(2);

    // Modulator density at pcm = 128
    v = '{8'd128, 8'd0, 1'b0, 1'b0, 1'b0, 128, 128};
    apply_stimulus(v, "sd_setup");
    tick(4);
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      tick(1);
      if (dout) ones++;
    end
    check_output("dout_density_128", ones, 128);

    // Fade-out to MUTED
    mute = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      expect_pcm($sformatf("fade_out_k%0d", k), 256 * k + 2, 8 * (16 - k), 1'b0);
    end
    tick(1);
    check_output("fade_out_busy", int'(busy), 1);
    tick(4095);
    check_output("fade_out_busy_before_end", int'(busy), 1);
    tick(1);
    check_output("muted_not_busy", int'(busy), 0);
    tick(1);
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (dout) ones++;
    end
    check_output("muted_dout_zero", ones, 0);

    // Back to RUN
    mute = 1'b0;
    tick(1);
    guard = 0;
    while (busy && guard < 6000) begin
      tick(1);
      guard++;
    end
    check_output("refade_done", int'(busy), 0);
    expect_pcm("refade_pcm", 1, 128, 1'b0);
    tick(2);

    // Fade out to gain 9, then reset asynchronously mid-fade
    mute = 1'b1;
    expect_pcm("fade_out_gain10", 1538, 80, 1'b0);
    expect_pcm("fade_out_gain9", 1794, 72, 1'b0);
    tick(1794);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_output("async_reset_pcm", int'(pcm), 0);
    check_output("async_reset_dout", int'(dout), 0);
    check_output("async_reset_busy", int'(busy), 1);
    mute     = 1'b0;
    ce       = 1'b1;
    soundbox = 8'd128;
    aux      = 8'd0;
    beeper   = 1'b0;
    ear      = 1'b0;
    mic      = 1'b0;
    tick(1);
    reset = 1'b0;
    expect_pcm("post_reset_gain0", 2, 0, 1'b0);
    expect_pcm("post_reset_gain1", 257, 8, 1'b0);
    expect_pcm("post_reset_gain2", 513, 16, 1'b0);
    tick(520);

    check_output("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
